// File: rtl/pulse_meter_pkg.sv
// Shared definitions for the pulse measurement blocks.
//   state_t         : measurement FSM states
//   DEF_WIDTH       : default counter width
//   DEF_SYNC_STAGES : default synchronizer depth on the asynchronous input
//   sat_max()       : all-ones value of a w-bit counter (saturation ceiling)
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_SYNC_STAGES = 2;

  function automatic longint unsigned sat_max(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/pulse_meter_sync_edge_detect.sv
// sync_edge_detect: brings an asynchronous level into the clock domain and
// reports its edges.
//   clock     : system clock, rising edge
//   reset     : synchronous, active-high
//   signal_in : asynchronous level
//   s         : synchronized level
//   rise/fall : one-cycle strobes on s edges
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic signal_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   s_d;
  // Shifts in ones after reset; its top bit says s_d now holds a real sample
  // of signal_in rather than the reset value. Without it a level that was
  // already high at reset release would look like a rise.
  logic [SYNC_STAGES:0]   primed_sr;
  logic                   primed;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_ff   <= '0;
      s_d       <= 1'b0;
      primed_sr <= '0;
    end else begin
      sync_ff   <= {sync_ff[SYNC_STAGES-2:0], signal_in};
      s_d       <= sync_ff[SYNC_STAGES-1];
      primed_sr <= {primed_sr[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign s      = sync_ff[SYNC_STAGES-1];
  assign primed = primed_sr[SYNC_STAGES];
  assign rise   = primed &  s & ~s_d;
  assign fall   = primed & ~s &  s_d;

endmodule

// File: rtl/pulse_meter.sv
// pulse_meter: measures high time, low time and period (in clock cycles) of
// a pulse train and counts completed periods.
//   clock       : system clock, rising edge
//   reset       : synchronous, active-high
//   enable      : measurement enable; low returns to IDLE and clears counters
//   signal_in   : pulse train, asynchronous to clock
//   high_width  : high cycles of the last complete period (saturating)
//   low_width   : low cycles of that period (saturating)
//   period      : high_width + low_width, one bit wider so it never wraps
//   valid       : one-cycle strobe, new measurement on the outputs
//   pulse_count : completed periods since reset, wraps
//   overflow    : sticky, a reported width had saturated
module pulse_meter
  import pulse_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             signal_in,
  output logic [WIDTH-1:0] high_width,
  output logic [WIDTH-1:0] low_width,
  output logic [WIDTH:0]   period,
  output logic             valid,
  output logic [WIDTH-1:0] pulse_count,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic s, rise, fall;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock     (clock),
    .reset     (reset),
    .signal_in (signal_in),
    .s         (s),
    .rise      (rise),
    .fall      (fall)
  );

  state_t           state, state_next;
  logic [WIDTH-1:0] hcnt, hcnt_next;
  logic [WIDTH-1:0] lcnt, lcnt_next;
  logic [WIDTH-1:0] hlat, hlat_next;
  logic             vld_p0;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // p0: edge-driven phase tracking; vld_p0 marks the rise closing a period
  always_comb begin
    state_next = state;
    hcnt_next  = hcnt;
    lcnt_next  = lcnt;
    hlat_next  = hlat;
    vld_p0     = 1'b0;
    if (!enable) begin
      state_next = IDLE;
      hcnt_next  = '0;
      lcnt_next  = '0;
      hlat_next  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rise) begin
            hcnt_next  = CNT_ONE;
            state_next = HIGH;
          end
        end
        HIGH: begin
          if (fall) begin
            hlat_next  = hcnt;
            lcnt_next  = CNT_ONE;
            state_next = LOW;
          end else if (s) begin
            hcnt_next  = sat_inc(hcnt);
          end
        end
        LOW: begin
          // The closing rise also opens the next high phase, so
          // back-to-back periods lose no cycle.
          if (rise) begin
            vld_p0     = 1'b1;
            hcnt_next  = CNT_ONE;
            state_next = HIGH;
          end else if (!s) begin
            lcnt_next  = sat_inc(lcnt);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // p1: registered counters and published measurement
  always_ff @(posedge clock) begin
    if (reset) begin
      hcnt        <= '0;
      lcnt        <= '0;
      hlat        <= '0;
      high_width  <= '0;
      low_width   <= '0;
      period      <= '0;
      valid       <= 1'b0;
      pulse_count <= '0;
      overflow    <= 1'b0;
    end else begin
      hcnt  <= hcnt_next;
      lcnt  <= lcnt_next;
      hlat  <= hlat_next;
      valid <= vld_p0;
      if (vld_p0) begin
        high_width  <= hlat;
        low_width   <= lcnt;
        period      <= {1'b0, hlat} + {1'b0, lcnt};
        pulse_count <= pulse_count + 1'b1;
        if (hlat == CNT_MAX || lcnt == CNT_MAX) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter: a table of periodic waveforms with
// hand-computed widths, plus hand-written sequences for saturation, a pulse
// straddling reset, enable drop and mid-operation reset.
module tb_pulse_meter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, enable, sig8, sig4;

  logic [7:0] hw8, lw8, pc8;
  logic [8:0] per8;
  logic       vld8, ovf8;
  logic [3:0] hw4, lw4, pc4;
  logic [4:0] per4;
  logic       vld4, ovf4;

  pulse_meter #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .clock(clock), .reset(reset), .enable(enable), .signal_in(sig8),
    .high_width(hw8), .low_width(lw8), .period(per8), .valid(vld8),
    .pulse_count(pc8), .overflow(ovf8)
  );

  pulse_meter #(.WIDTH(4), .SYNC_STAGES(2)) dut4 (
    .clock(clock), .reset(reset), .enable(enable), .signal_in(sig4),
    .high_width(hw4), .low_width(lw4), .period(per4), .valid(vld4),
    .pulse_count(pc4), .overflow(ovf4)
  );

  typedef struct {
    int hi;
    int lo;
    int nper;
    int exp_hw;
    int exp_lw;
    int exp_per;
  } vec_t;

  vec_t vecs[4];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // valid-strobe log for each instance
  int   n8, n4, dbl8;
  logic pv8;
  int   lh8[16], ll8[16], lp8[16], lpc8[16], lc8[16];
  int   lh4[4], ll4[4], lp4[4], lpc4[4], lo4[4];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (vld8) begin
      if (n8 < 16) begin
        lh8[n8]  = int'(hw8);
        ll8[n8]  = int'(lw8);
        lp8[n8]  = int'(per8);
        lpc8[n8] = int'(pc8);
        lc8[n8]  = cyc;
      end
      n8++;
    end
    if (vld8 && pv8) dbl8++;
    pv8 = vld8;
    if (vld4) begin
      if (n4 < 4) begin
        lh4[n4]  = int'(hw4);
        ll4[n4]  = int'(lw4);
        lp4[n4]  = int'(per4);
        lpc4[n4] = int'(pc4);
        lo4[n4]  = int'(ovf4);
      end
      n4++;
    end
  endtask

  task automatic clear_log();
    n8 = 0; n4 = 0; dbl8 = 0; pv8 = 1'b0;
  endtask

  task automatic hold8(input logic b, input int n);
    sig8 = b;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic hold4(input logic b, input int n);
    sig4 = b;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input int n, input logic b8);
    reset = 1'b1; enable = 1'b1; sig8 = b8; sig4 = 1'b0;
    for (int i = 0; i < n; i++) tick();
    reset = 1'b0;
    clear_log();
  endtask

  initial begin
    int c0;
    vecs[0] = '{4, 4, 3, 4, 4, 8};
    vecs[1] = '{3, 5, 3, 3, 5, 8};
    vecs[2] = '{1, 1, 3, 1, 1, 2};
    vecs[3] = '{2, 7, 2, 2, 7, 9};

    // reset state
    do_reset(2, 1'b0);
    check("rst_high_width", int'(hw8), 0);
    check("rst_low_width", int'(lw8), 0);
    check("rst_period", int'(per8), 0);
    check("rst_valid", int'(vld8), 0);
    check("rst_pulse_count", int'(pc8), 0);
    check("rst_overflow", int'(ovf8), 0);
    check("rst_overflow_w4", int'(ovf4), 0);
    check("rst_pulse_count_w4", int'(pc4), 0);

    // periodic waveforms from the table
    for (int r = 0; r < 4; r++) begin
      do_reset(1, 1'b0);
      hold8(1'b0, 4);
      c0 = cyc;
      for (int p = 0; p < vecs[r].nper; p++) begin
        hold8(1'b1, vecs[r].hi);
        hold8(1'b0, vecs[r].lo);
      end
      hold8(1'b1, 4);
      check($sformatf("row%0d_valid_count", r), n8, vecs[r].nper);
      for (int i = 0; i < vecs[r].nper && i < n8 && i < 16; i++) begin
        check($sformatf("row%0d_v%0d_high", r, i), lh8[i], vecs[r].exp_hw);
        check($sformatf("row%0d_v%0d_low", r, i), ll8[i], vecs[r].exp_lw);
        check($sformatf("row%0d_v%0d_period", r, i), lp8[i], vecs[r].exp_per);
        check($sformatf("row%0d_v%0d_count", r, i), lpc8[i], i + 1);
        if (i > 0)
          check($sformatf("row%0d_v%0d_spacing", r, i), lc8[i] - lc8[i-1],
                vecs[r].hi + vecs[r].lo);
      end
      if (n8 > 0)
        check($sformatf("row%0d_latency", r),
              lc8[0] - (c0 + vecs[r].hi + vecs[r].lo + 1) + 1, 3);
      check($sformatf("row%0d_strobe_width", r), dbl8, 0);
      check($sformatf("row%0d_overflow", r), int'(ovf8), 0);
    end

    // saturation on the 4-bit instance
    do_reset(1, 1'b0);
    hold4(1'b0, 4);
    hold4(1'b1, 20);
    check("sat_no_valid_while_high", n4, 0);
    check("sat_overflow_before_report", int'(ovf4), 0);
    hold4(1'b0, 2);
    hold4(1'b1, 4);
    check("sat_valid_count", n4, 1);
    check("sat_high", lh4[0], 15);
    check("sat_low", ll4[0], 2);
    check("sat_period", lp4[0], 17);
    check("sat_overflow", lo4[0], 1);
    check("sat_pulse_count", lpc4[0], 1);
    hold4(1'b0, 4);
    hold4(1'b1, 4);
    check("sat_valid_count2", n4, 2);
    check("sat_high2", lh4[1], 4);
    check("sat_low2", ll4[1], 4);
    check("sat_period2", lp4[1], 8);
    check("sat_overflow_sticky", int'(ovf4), 1);
    check("sat_pulse_count2", int'(pc4), 2);

    // signal already high across reset: partial pulse ignored
    do_reset(2, 1'b1);
    hold8(1'b1, 6);
    hold8(1'b0, 4);
    hold8(1'b1, 4);
    hold8(1'b0, 4);
    hold8(1'b1, 4);
    check("partial_valid_count", n8, 1);
    check("partial_high", lh8[0], 4);
    check("partial_low", ll8[0], 4);
    check("partial_pulse_count", lpc8[0], 1);

    // enable dropped mid-high, outputs hold, restart at next rise
    do_reset(1, 1'b0);
    hold8(1'b0, 4);
    hold8(1'b1, 3);
    hold8(1'b0, 5);
    hold8(1'b1, 3);
    check("en_first_valid", n8, 1);
    enable = 1'b0;
    hold8(1'b1, 1);
    hold8(1'b0, 4);
    hold8(1'b1, 4);
    hold8(1'b0, 2);
    check("en_no_valid_disabled", n8, 1);
    check("en_hold_high", int'(hw8), 3);
    check("en_hold_low", int'(lw8), 5);
    check("en_hold_period", int'(per8), 8);
    check("en_hold_count", int'(pc8), 1);
    check("en_valid_low", int'(vld8), 0);
    enable = 1'b1;
    hold8(1'b0, 2);
    hold8(1'b1, 4);
    hold8(1'b0, 4);
    hold8(1'b1, 4);
    check("en_restart_valid_count", n8, 2);
    check("en_restart_high", lh8[1], 4);
    check("en_restart_low", ll8[1], 4);
    check("en_restart_count", lpc8[1], 2);

    // reset during LOW after two measurements
    do_reset(1, 1'b0);
    hold8(1'b0, 4);
    hold8(1'b1, 4);
    hold8(1'b0, 4);
    hold8(1'b1, 4);
    hold8(1'b0, 4);
    hold8(1'b1, 4);
    hold8(1'b0, 4);
    check("mid_rst_two_valids", n8, 2);
    check("mid_rst_count_before", int'(pc8), 2);
    do_reset(1, 1'b0);
    check("mid_rst_high", int'(hw8), 0);
    check("mid_rst_low", int'(lw8), 0);
    check("mid_rst_period", int'(per8), 0);
    check("mid_rst_valid", int'(vld8), 0);
    check("mid_rst_count", int'(pc8), 0);
    check("mid_rst_overflow", int'(ovf8), 0);
    hold8(1'b0, 4);
    hold8(1'b1, 4);
    hold8(1'b0, 4);
    hold8(1'b1, 4);
    check("post_rst_valid_count", n8, 1);
    check("post_rst_pulse_count", lpc8[0], 1);
    check("post_rst_high", lh8[0], 4);
    check("post_rst_low", ll8[0], 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
